snake_engine: RTL and testbench
===============================

Name: snake_engine

Overview:
- Parametrised grid-level snake game engine. Holds head and body segments in a MAX_LEN-deep register array, advances one cell per step tick, grows on apple capture, and detects wall and self collisions on grid coordinates.
- Runs in the CLK100MHZ domain. Sits between the direction/tick logic and the VGA pixel renderer.
- The renderer supplies the grid cell of the current pixel and receives registered hit flags.

Parameters:
- GRID_W, 16, grid width in cells; column 0 and column GRID_W-1 are border.
- GRID_H, 12, grid height in cells; row 0 and row GRID_H-1 are border.
- MAX_LEN, 8, segment capacity including head (≥2).
- INIT_LEN, 3, length after reset or restart (2..MAX_LEN).
- COORD_W, 4, coordinate width; must hold max(GRID_W,GRID_H)-1.
- LEN_W, 4, length counter width; must hold MAX_LEN.

Ports:
- CLK100MHZ  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  level; IDLE->RUN, or OVER->RUN with re-init
- step_tick  in  1  one-cycle move strobe
- dir_req  in  4  one-hot: 0001 left, 0010 right, 0100 up, 1000 down
- apple_x / apple_y  in  COORD_W each  apple cell
- apple_valid  in  1  apple present
- query_x / query_y  in  COORD_W each  cell under current pixel
- head_x / head_y  out  COORD_W each  committed head cell
- length  out  LEN_W  active segments
- apple_eaten  out  1  one-cycle pulse on capture
- game_over  out  1  high while in OVER
- busy  out  1  high in CHECK/COMMIT
- query_head / query_body / query_border  out  1 each  registered hits
- query_odd  out  1  body hit index is odd (for alternating colours)

Behaviour:
- Clock and reset: one clock, CLK100MHZ. reset_n is asynchronous and active-low.
- Reset state:
  - State IDLE; heading right.
  - seg[i] = (GRID_W/2 - i, GRID_H/2) for all i; length=INIT_LEN.
  - All pulses and query outputs 0; game_over=0.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: step_tick -> CHECK.
  - CHECK: fixed MAX_LEN-1 cycles, then COMMIT.
  - COMMIT: one cycle, then RUN or OVER.
  - OVER: start -> RUN.
- Heading update, sampled on the RUN tick:
  - A one-hot dir_req replaces heading unless it is the exact reverse of the current heading (reverse is ignored).
  - Zero or non-one-hot dir_req keeps the current heading.
- Next head: nh = head ± 1 on one axis, computed with COORD_W modular arithmetic and latched on the tick.
- grow = apple_valid && nh==(apple_x,apple_y), latched on the tick.
- CHECK scan:
  - Index i runs 1..MAX_LEN-1, one per cycle.
  - i is active if i<length-1, or i==length-1 when grow.
  - Collision flag is set if active seg[i]==nh. Inactive indices still consume a cycle (deterministic latency).
- COMMIT:
  - Collision, or nh on a border cell -> OVER; segments unchanged.
  - Otherwise shift seg[i]<=seg[i-1] and seg[0]<=nh.
  - If grow: length<=min(length+1, MAX_LEN) and apple_eaten=1 for this cycle only. At MAX_LEN the pulse still fires and length holds.
- Latency: tick at cycle T -> new head_x/head_y visible at T+MAX_LEN+1 (9 for default).
- step_tick in IDLE, CHECK, COMMIT or OVER is dropped, not queued.
- Restart: start in OVER reloads reset positions, heading and length in that cycle, and enters RUN next cycle. game_over falls with the state change.
- Query path (1-cycle registered latency):
  - query_head = (query==seg[0]).
  - query_body = any seg[i]==query for 1≤i<length.
  - query_odd = lowest matching i is odd.
  - query_border = query on row 0 / GRID_H-1 or column 0 / GRID_W-1.
  - Query values outside the grid give all flags 0 except query_border, which is also 0.
- Reset mid-operation: reset_n low during CHECK/COMMIT aborts the move immediately; no apple_eaten is emitted.

Optional Feature:
- Macro SNAKE_WRAP_WALLS_EN.
- When defined:
  - Border cells are not fatal.
  - nh leaving the interior wraps: column 0 -> GRID_W-2, column GRID_W-1 -> 1; same for rows.
  - Only self collision ends the game.
  - query_border is still reported.
- When undefined: entering any border cell -> OVER.

Decomposition:
- Shared package snake_pkg holds:
  - state encoding (IDLE, RUN, CHECK, COMMIT, OVER)
  - direction one-hot constants DIR_LEFT/RIGHT/UP/DOWN
  - an opposite-direction function
  - GRID_SIZE pixel constant for the renderer
- One sub-module: snake_query_match, the combinational query comparator bank plus its output register.

Test Plan:
- Reset, start, 3 ticks heading right (GRID 16x12) -> head (8,6)->(9,6)->(10,6)->(11,6); each update exactly 9 cycles after its tick; length stays 3.
- Heading right, dir_req=0001 (left) then tick -> reverse ignored, head advances right; dir_req=0100 -> head y decrements.
- apple at (9,6) valid, one tick -> apple_eaten pulses one cycle in COMMIT; length 3->4; query at old tail cell reports query_body=1.
- Drive head to x=14 then tick right -> OVER, game_over=1, head stays (14,6); with SNAKE_WRAP_WALLS_EN, head becomes (1,6) and RUN continues.
- Length 5, sequence up, left, down -> nh hits seg[3] -> OVER; a tick issued during CHECK is dropped (head moves once only).
- reset_n low during CHECK -> immediate reset state, no apple_eaten; query (8,6) one cycle later -> query_head=1, query (7,6) -> query_body=1, query_odd=1.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake engine: FSM state codes, one-hot
// direction constants, the reverse-direction helper and renderer cell size.
package snake_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_OVER   = 3'd4;

  localparam logic [3:0] DIR_LEFT  = 4'b0001;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_DOWN  = 4'b1000;

  // Edge length of one grid cell in pixels, used by the VGA renderer.
  localparam int unsigned GRID_SIZE = 40;

  function automatic logic [3:0] dir_opposite(input logic [3:0] d);
    case (d)
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic logic dir_is_onehot(input logic [3:0] d);
    return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/snake_query_match.sv
// Pixel query comparator bank: compares the renderer's current cell with the
// head, the active body segments and the border, and registers the flags.
module snake_query_match
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W  = 16,
  parameter int unsigned GRID_H  = 12,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned COORD_W = 4,
  parameter int unsigned LEN_W   = 4
) (
  input  logic                              CLK100MHZ,
  input  logic                              reset_n,
  input  logic [COORD_W-1:0]                query_x,
  input  logic [COORD_W-1:0]                query_y,
  input  logic [MAX_LEN-1:0][COORD_W-1:0]   seg_x,
  input  logic [MAX_LEN-1:0][COORD_W-1:0]   seg_y,
  input  logic [LEN_W-1:0]                  length,
  output logic                              query_head,
  output logic                              query_body,
  output logic                              query_border,
  output logic                              query_odd
);

  logic [31:0] qx, qy;
  logic        head_hit, body_hit, odd_hit, border_hit, in_grid;

  assign qx = 32'(query_x);
  assign qy = 32'(query_y);

  // Combinational match of the query cell against head, body and border.
  always_comb begin
    in_grid    = (qx < GRID_W) && (qy < GRID_H);
    head_hit   = (query_x == seg_x[0]) && (query_y == seg_y[0]);
    border_hit = in_grid && ((qx == 0) || (qx == GRID_W - 1) ||
                             (qy == 0) || (qy == GRID_H - 1));
    body_hit   = 1'b0;
    odd_hit    = 1'b0;
    for (int unsigned i = 1; i < MAX_LEN; i++) begin
      if (!body_hit && (LEN_W'(i) < length) &&
          (query_x == seg_x[i]) && (query_y == seg_y[i])) begin
        body_hit = 1'b1;
        odd_hit  = i[0];
      end
    end
  end

  // Register the flags so the renderer sees them one cycle after the query.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      query_head   <= 1'b0;
      query_body   <= 1'b0;
      query_border <= 1'b0;
      query_odd    <= 1'b0;
    end else begin
      query_head   <= head_hit;
      query_body   <= body_hit;
      query_border <= border_hit;
      query_odd    <= odd_hit;
    end
  end

endmodule

// File: rtl/snake_engine.sv
// Grid-level snake engine: segment store, move FSM with a fixed-latency
// self-collision scan, apple growth and wall handling.
// Optional macro SNAKE_WRAP_WALLS_EN: borders wrap to the opposite interior
// cell instead of ending the game.
module snake_engine
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W   = 16,
  parameter int unsigned GRID_H   = 12,
  parameter int unsigned MAX_LEN  = 8,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned COORD_W  = 4,
  parameter int unsigned LEN_W    = 4
) (
  input  logic               CLK100MHZ,
  input  logic               reset_n,
  input  logic               start,
  input  logic               step_tick,
  input  logic [3:0]         dir_req,
  input  logic [COORD_W-1:0] apple_x,
  input  logic [COORD_W-1:0] apple_y,
  input  logic               apple_valid,
  input  logic [COORD_W-1:0] query_x,
  input  logic [COORD_W-1:0] query_y,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [LEN_W-1:0]   length,
  output logic               apple_eaten,
  output logic               game_over,
  output logic               busy,
  output logic               query_head,
  output logic               query_body,
  output logic               query_border,
  output logic               query_odd
);

  localparam int unsigned IDX_W = $clog2(MAX_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_LEN - 1);

  logic [2:0]                       state;
  logic [3:0]                       heading, new_heading;
  logic [MAX_LEN-1:0][COORD_W-1:0]  seg_x, seg_y;
  logic [LEN_W-1:0]                 len_q;
  logic [COORD_W-1:0]               nh_x, nh_y, cand_x, cand_y;
  logic                             grow_q, collide_q, cand_grow;
  logic [IDX_W-1:0]                 scan_i;
  logic                             scan_active, scan_hit, fatal;

  // Heading for this tick: one-hot requests win unless they reverse the snake.
  always_comb begin
    new_heading = heading;
    if (dir_is_onehot(dir_req) && (dir_req != dir_opposite(heading)))
      new_heading = dir_req;
  end

  // Candidate next head, modular step on one axis, optional border wrap.
  always_comb begin
    cand_x = seg_x[0];
    cand_y = seg_y[0];
    case (new_heading)
      DIR_LEFT:  cand_x = seg_x[0] - COORD_W'(1);
      DIR_RIGHT: cand_x = seg_x[0] + COORD_W'(1);
      DIR_UP:    cand_y = seg_y[0] - COORD_W'(1);
      DIR_DOWN:  cand_y = seg_y[0] + COORD_W'(1);
      default:   ;
    endcase
`ifdef SNAKE_WRAP_WALLS_EN
    if (cand_x == '0)                       cand_x = COORD_W'(GRID_W - 2);
    else if (cand_x >= COORD_W'(GRID_W - 1)) cand_x = COORD_W'(1);
    if (cand_y == '0)                       cand_y = COORD_W'(GRID_H - 2);
    else if (cand_y >= COORD_W'(GRID_H - 1)) cand_y = COORD_W'(1);
`endif
    cand_grow = apple_valid && (cand_x == apple_x) && (cand_y == apple_y);
  end

  // Scan step and commit decision; the tail only counts when it stays put.
  always_comb begin
    scan_active = (LEN_W'(scan_i) < (len_q - LEN_W'(1))) ||
                  (grow_q && (LEN_W'(scan_i) == (len_q - LEN_W'(1))));
    scan_hit    = scan_active && (seg_x[scan_i] == nh_x) && (seg_y[scan_i] == nh_y);
`ifdef SNAKE_WRAP_WALLS_EN
    fatal = collide_q;
`else
    fatal = collide_q || (nh_x == '0) || (nh_x >= COORD_W'(GRID_W - 1)) ||
            (nh_y == '0) || (nh_y >= COORD_W'(GRID_H - 1));
`endif
  end

  // Game FSM and segment store.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      heading   <= DIR_RIGHT;
      len_q     <= LEN_W'(INIT_LEN);
      nh_x      <= '0;
      nh_y      <= '0;
      grow_q    <= 1'b0;
      collide_q <= 1'b0;
      scan_i    <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= COORD_W'(GRID_W / 2 - i);
        seg_y[i] <= COORD_W'(GRID_H / 2);
      end
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_RUN;
        ST_RUN: begin
          if (step_tick) begin
            heading   <= new_heading;
            nh_x      <= cand_x;
            nh_y      <= cand_y;
            grow_q    <= cand_grow;
            collide_q <= 1'b0;
            scan_i    <= IDX_W'(1);
            state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (scan_hit) collide_q <= 1'b1;
          if (scan_i == LAST_IDX) state <= ST_COMMIT;
          else                    scan_i <= scan_i + IDX_W'(1);
        end
        ST_COMMIT: begin
          if (fatal) begin
            state <= ST_OVER;
          end else begin
            for (int unsigned i = 1; i < MAX_LEN; i++) begin
              seg_x[i] <= seg_x[i-1];
              seg_y[i] <= seg_y[i-1];
            end
            seg_x[0] <= nh_x;
            seg_y[0] <= nh_y;
            if (grow_q && (len_q < LEN_W'(MAX_LEN))) len_q <= len_q + LEN_W'(1);
            state <= ST_RUN;
          end
        end
        ST_OVER: begin
          if (start) begin
            heading <= DIR_RIGHT;
            len_q   <= LEN_W'(INIT_LEN);
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
              seg_x[i] <= COORD_W'(GRID_W / 2 - i);
              seg_y[i] <= COORD_W'(GRID_H / 2);
            end
            state <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign head_x      = seg_x[0];
  assign head_y      = seg_y[0];
  assign length      = len_q;
  assign game_over   = (state == ST_OVER);
  assign busy        = (state == ST_CHECK) || (state == ST_COMMIT);
  assign apple_eaten = (state == ST_COMMIT) && grow_q && !fatal;

  snake_query_match #(
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H),
    .MAX_LEN (MAX_LEN),
    .COORD_W (COORD_W),
    .LEN_W   (LEN_W)
  ) u_query (
    .CLK100MHZ    (CLK100MHZ),
    .reset_n      (reset_n),
    .query_x      (query_x),
    .query_y      (query_y),
    .seg_x        (seg_x),
    .seg_y        (seg_y),
    .length       (len_q),
    .query_head   (query_head),
    .query_body   (query_body),
    .query_border (query_border),
    .query_odd    (query_odd)
  );

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: a behavioural snake model predicts each
// move, expectations go through a scoreboard queue and are checked at commit.
module tb_snake_engine;

  localparam int GW = 16, GH = 12, ML = 8, IL = 3;

  logic       CLK100MHZ = 1'b0;
  logic       reset_n, start, step_tick, apple_valid;
  logic [3:0] dir_req, apple_x, apple_y, query_x, query_y;
  logic [3:0] head_x, head_y, length;
  logic       apple_eaten, game_over, busy;
  logic       query_head, query_body, query_border, query_odd;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int hx;
    int hy;
    int len;
    bit eaten;
    bit over;
  } exp_t;
  exp_t sb[$];

  int         mx[ML];
  int         my[ML];
  int         mlen;
  logic [3:0] mdir;
  bit         mover;

  always #5 CLK100MHZ = ~CLK100MHZ;

  snake_engine #(
    .GRID_W(16), .GRID_H(12), .MAX_LEN(8), .INIT_LEN(3), .COORD_W(4), .LEN_W(4)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .reset_n(reset_n), .start(start), .step_tick(step_tick),
    .dir_req(dir_req), .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
    .query_x(query_x), .query_y(query_y), .head_x(head_x), .head_y(head_y),
    .length(length), .apple_eaten(apple_eaten), .game_over(game_over), .busy(busy),
    .query_head(query_head), .query_body(query_body), .query_border(query_border),
    .query_odd(query_odd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ML; i++) begin
      mx[i] = GW / 2 - i;
      my[i] = GH / 2;
    end
    mlen  = IL;
    mdir  = 4'b0010;
    mover = 1'b0;
  endtask

  task automatic model_tick(input logic [3:0] d, output exp_t e);
    int nx, ny;
    bit grow, hit, wall;
    logic [3:0] rev;
    case (mdir)
      4'b0001: rev = 4'b0010;
      4'b0010: rev = 4'b0001;
      4'b0100: rev = 4'b1000;
      default: rev = 4'b0100;
    endcase
    if ((d == 4'b0001 || d == 4'b0010 || d == 4'b0100 || d == 4'b1000) && d != rev) mdir = d;
    nx = mx[0];
    ny = my[0];
    case (mdir)
      4'b0001: nx = nx - 1;
      4'b0010: nx = nx + 1;
      4'b0100: ny = ny - 1;
      default: ny = ny + 1;
    endcase
    wall = (nx <= 0) || (nx >= GW - 1) || (ny <= 0) || (ny >= GH - 1);
`ifdef SNAKE_WRAP_WALLS_EN
    if (nx <= 0) nx = GW - 2; else if (nx >= GW - 1) nx = 1;
    if (ny <= 0) ny = GH - 2; else if (ny >= GH - 1) ny = 1;
    wall = 1'b0;
`endif
    grow = apple_valid && (nx == int'(apple_x)) && (ny == int'(apple_y));
    hit = 1'b0;
    for (int i = 1; i < mlen; i++)
      if ((i < mlen - 1 || grow) && mx[i] == nx && my[i] == ny) hit = 1'b1;
    e.eaten = 1'b0;
    if (hit || wall) begin
      mover = 1'b1;
    end else begin
      for (int i = ML - 1; i > 0; i--) begin
        mx[i] = mx[i-1];
        my[i] = my[i-1];
      end
      mx[0] = nx;
      my[0] = ny;
      if (grow) begin
        e.eaten = 1'b1;
        if (mlen < ML) mlen++;
      end
    end
    e.hx = mx[0];
    e.hy = my[0];
    e.len = mlen;
    e.over = mover;
  endtask

  // One move: tick, check hold-off and pulse in COMMIT, compare result after.
  task automatic do_tick(input logic [3:0] d, input bit extra, input string tag);
    exp_t e, got;
    int ohx, ohy;
    ohx = mx[0];
    ohy = my[0];
    model_tick(d, e);
    sb.push_back(e);
    dir_req = d;
    step_tick = 1'b1;
    @(posedge CLK100MHZ); #1;
    step_tick = 1'b0;
    dir_req = 4'b0000;
    if (extra) begin
      step_tick = 1'b1;
      @(posedge CLK100MHZ); #1;
      step_tick = 1'b0;
      repeat (6) @(posedge CLK100MHZ);
    end else begin
      repeat (7) @(posedge CLK100MHZ);
    end
    #1;
    chk({tag, ".busy_commit"}, busy, 1);
    chk({tag, ".hold_x"}, head_x, ohx);
    chk({tag, ".hold_y"}, head_y, ohy);
    chk({tag, ".eaten"}, apple_eaten, e.eaten);
    @(posedge CLK100MHZ); #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
    end else begin
      got = sb.pop_front();
      chk({tag, ".head_x"}, head_x, got.hx);
      chk({tag, ".head_y"}, head_y, got.hy);
      chk({tag, ".length"}, length, got.len);
      chk({tag, ".game_over"}, game_over, got.over);
      chk({tag, ".eaten_end"}, apple_eaten, 0);
      chk({tag, ".busy_end"}, busy, 0);
    end
  endtask

  task automatic do_query(input int qx, input int qy, input bit eh, input bit eb,
                          input bit eo, input bit ebd, input string tag);
    query_x = 4'(qx);
    query_y = 4'(qy);
    @(posedge CLK100MHZ); #1;
    chk({tag, ".q_head"}, query_head, eh);
    chk({tag, ".q_body"}, query_body, eb);
    chk({tag, ".q_odd"}, query_odd, eo);
    chk({tag, ".q_border"}, query_border, ebd);
  endtask

  initial begin
    bit saw_eaten;
    reset_n = 1'b0; start = 1'b0; step_tick = 1'b0; dir_req = 4'b0000;
    apple_x = 4'd0; apple_y = 4'd0; apple_valid = 1'b0;
    query_x = 4'd0; query_y = 4'd0;
    model_reset();
    repeat (3) @(posedge CLK100MHZ); #1;
    chk("rst.head_x", head_x, 8);
    chk("rst.head_y", head_y, 6);
    chk("rst.length", length, 3);
    chk("rst.game_over", game_over, 0);
    chk("rst.busy", busy, 0);
    chk("rst.eaten", apple_eaten, 0);
    chk("rst.q_border", query_border, 0);
    reset_n = 1'b1;

    // Tick in IDLE must be dropped.
    step_tick = 1'b1;
    @(posedge CLK100MHZ); #1;
    step_tick = 1'b0;
    repeat (10) @(posedge CLK100MHZ); #1;
    chk("idle_tick.busy", busy, 0);
    chk("idle_tick.head_x", head_x, 8);

    start = 1'b1;
    @(posedge CLK100MHZ); #1;
    start = 1'b0;

    apple_x = 4'd9; apple_y = 4'd6; apple_valid = 1'b1;
    do_tick(4'b0010, 1'b0, "grow");
    apple_valid = 1'b0;
    do_query(6, 6, 0, 1, 1, 0, "old_tail");
    do_query(9, 6, 1, 0, 0, 0, "new_head");

    do_tick(4'b0001, 1'b0, "reverse");
    do_tick(4'b0000, 1'b1, "drop");
    repeat (12) @(posedge CLK100MHZ); #1;
    chk("drop.busy_after", busy, 0);
    chk("drop.head_x_after", head_x, 11);
    do_tick(4'b0100, 1'b0, "up");
    apple_x = 4'd10; apple_y = 4'd5; apple_valid = 1'b1;
    do_tick(4'b0001, 1'b0, "left_grow");
    apple_valid = 1'b0;
    do_tick(4'b1000, 1'b0, "self_hit");
    chk("self_hit.over_const", game_over, 1);

    // Restart from OVER.
    start = 1'b1;
    @(posedge CLK100MHZ); #1;
    start = 1'b0;
    model_reset();
    chk("restart.game_over", game_over, 0);
    chk("restart.head_x", head_x, 8);
    chk("restart.length", length, 3);

    for (int k = 0; k < 7; k++) do_tick(4'b0010, 1'b0, "wall");
`ifdef SNAKE_WRAP_WALLS_EN
    chk("wall.final_x", head_x, 1);
    chk("wall.final_over", game_over, 0);
`else
    chk("wall.final_x", head_x, 14);
    chk("wall.final_over", game_over, 1);
`endif
    do_query(0, 3, 0, 0, 0, 1, "border_left");
    do_query(15, 11, 0, 0, 0, 1, "border_corner");
    do_query(14, 12, 0, 0, 0, 0, "outside");
    do_query(5, 5, 0, 0, 0, 0, "interior");

    // Abort a growing move with reset during CHECK.
    if (mover) begin
      start = 1'b1;
      @(posedge CLK100MHZ); #1;
      start = 1'b0;
      model_reset();
    end
    apple_x = 4'(mx[0] + 1); apple_y = 4'(my[0]); apple_valid = 1'b1;
    dir_req = 4'b0010;
    step_tick = 1'b1;
    @(posedge CLK100MHZ); #1;
    step_tick = 1'b0;
    dir_req = 4'b0000;
    repeat (3) @(posedge CLK100MHZ); #1;
    chk("abort.busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.eaten", apple_eaten, 0);
    chk("abort.head_x", head_x, 8);
    chk("abort.head_y", head_y, 6);
    chk("abort.length", length, 3);
    chk("abort.game_over", game_over, 0);
    saw_eaten = 1'b0;
    repeat (2) @(posedge CLK100MHZ);
    #1 reset_n = 1'b1;
    apple_valid = 1'b0;
    model_reset();
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK100MHZ); #1;
      if (apple_eaten === 1'b1) saw_eaten = 1'b1;
    end
    chk("abort.no_eaten_later", saw_eaten, 0);
    do_query(8, 6, 1, 0, 0, 0, "post_rst_head");
    do_query(7, 6, 0, 1, 1, 0, "post_rst_body1");
    do_query(6, 6, 0, 1, 0, 0, "post_rst_body2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
